// File: rtl/scrambler_pkg.sv
// Shared constants for the 30-bit frame scrambler: frame width, default seed,
// feedback tap offsets and the 30-bit 2-of-3 majority voter used by the TMR build.
package scrambler_pkg;

    localparam int                 FRAME_W      = 30;
    localparam logic [FRAME_W-1:0] SEED_DEFAULT = 30'h2AAAAAAA;
    localparam int                 NTAPS        = 4;
    localparam int                 TAPS [NTAPS] = '{0, 1, 15, 16};

    function automatic logic [FRAME_W-1:0] vote3(
        input logic [FRAME_W-1:0] a,
        input logic [FRAME_W-1:0] b,
        input logic [FRAME_W-1:0] c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/scrambler30_core.sv
// Combinational 30-bit self-synchronising scramble of one frame against the
// previous 30 scrambled bits held in state.
module scrambler30_core
    import scrambler_pkg::*;
(
    input  logic [FRAME_W-1:0] data,
    input  logic [FRAME_W-1:0] state,
    output logic [FRAME_W-1:0] y
);

    // x is the bit stream: old scrambled bits below, this frame's bits above,
    // so high taps of late bits pick up bits produced earlier in the same frame
    logic [2*FRAME_W-1:0] x;
    logic                 b;

    always_comb begin
        x                = '0;
        b                = 1'b0;
        x[FRAME_W-1:0]   = state;
        for (int i = 0; i < FRAME_W; i++) begin
            b = data[i];
            for (int t = 0; t < NTAPS; t++) begin
                b = b ^ x[i + TAPS[t]];
            end
            x[FRAME_W + i] = b;
        end
        y = x[2*FRAME_W-1:FRAME_W];
    end

endmodule

// File: rtl/frame_scrambler30.sv
// Frame scrambler with 1-deep output register, bypass, init and frame counter.
// Define SCRAMBLER_TMR_EN to triplicate the registers behind majority voters.
module frame_scrambler30
    import scrambler_pkg::*;
#(
    parameter logic [FRAME_W-1:0] SEED  = SEED_DEFAULT,
    parameter int                 CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               init,
    input  logic [FRAME_W-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [FRAME_W-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   frame_cnt,
    output logic               tmr_error
);

    logic [FRAME_W-1:0] state_v;
    logic [FRAME_W-1:0] data_v;
    logic               vld_v;
    logic [CNT_W-1:0]   cnt_v;

    logic [FRAME_W-1:0] y_p0;
    logic               accept_p0;
    logic [FRAME_W-1:0] state_nxt;
    logic [FRAME_W-1:0] data_nxt;
    logic               vld_nxt;
    logic [CNT_W-1:0]   cnt_nxt;

    assign in_ready  = !vld_v || out_ready;
    assign accept_p0 = in_valid && in_ready;

    scrambler30_core u_core (
        .data  (in_data),
        .state (state_v),
        .y     (y_p0)
    );

    // init overrides the state/counter update but the frame in flight still
    // uses the old state, since y_p0 is computed from state_v
    always_comb begin
        state_nxt = state_v;
        data_nxt  = data_v;
        vld_nxt   = vld_v;
        cnt_nxt   = cnt_v;
        if (accept_p0) begin
            data_nxt = enable ? y_p0 : in_data;
            vld_nxt  = 1'b1;
            if (enable) begin
                state_nxt = y_p0;
                cnt_nxt   = cnt_v + 1'b1;
            end
        end else if (out_ready) begin
            vld_nxt = 1'b0;
        end
        if (init) begin
            state_nxt = SEED;
            cnt_nxt   = '0;
        end
    end

    // ---- stage p1: output register ----
`ifdef SCRAMBLER_TMR_EN
    logic [2:0][FRAME_W-1:0] st_q;
    logic [2:0][FRAME_W-1:0] data_p1;
    logic [2:0]              vld_p1;
    logic [2:0][CNT_W-1:0]   cnt_q;
    logic                    mismatch;
    logic                    tmr_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q      <= {3{SEED}};
            data_p1   <= '0;
            vld_p1    <= '0;
            cnt_q     <= '0;
            tmr_err_q <= 1'b0;
        end else begin
            st_q      <= {3{state_nxt}};
            data_p1   <= {3{data_nxt}};
            vld_p1    <= {3{vld_nxt}};
            cnt_q     <= {3{cnt_nxt}};
            tmr_err_q <= mismatch;
        end
    end

    assign state_v = vote3(st_q[0], st_q[1], st_q[2]);
    assign data_v  = vote3(data_p1[0], data_p1[1], data_p1[2]);
    assign vld_v   = (vld_p1[0] & vld_p1[1]) | (vld_p1[0] & vld_p1[2]) | (vld_p1[1] & vld_p1[2]);
    assign cnt_v   = (cnt_q[0] & cnt_q[1]) | (cnt_q[0] & cnt_q[2]) | (cnt_q[1] & cnt_q[2]);

    assign mismatch = (st_q[0] != st_q[1]) || (st_q[1] != st_q[2]) ||
                      (data_p1[0] != data_p1[1]) || (data_p1[1] != data_p1[2]) ||
                      (vld_p1[0] != vld_p1[1]) || (vld_p1[1] != vld_p1[2]) ||
                      (cnt_q[0] != cnt_q[1]) || (cnt_q[1] != cnt_q[2]);

    assign tmr_error = tmr_err_q;
`else
    logic [FRAME_W-1:0] st_q;
    logic [FRAME_W-1:0] data_p1;
    logic               vld_p1;
    logic [CNT_W-1:0]   cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q    <= SEED;
            data_p1 <= '0;
            vld_p1  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            st_q    <= state_nxt;
            data_p1 <= data_nxt;
            vld_p1  <= vld_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    assign state_v   = st_q;
    assign data_v    = data_p1;
    assign vld_v     = vld_p1;
    assign cnt_v     = cnt_q;
    assign tmr_error = 1'b0;
`endif

    assign out_data  = data_v;
    assign out_valid = vld_v;
    assign frame_cnt = cnt_v;

endmodule

// File: tb/tb_frame_scrambler30.sv
// Scoreboard bench for frame_scrambler30: serial-stream reference scrambler,
// descrambler loopback, bypass, backpressure, counter wrap, init and reset cases.
module tb_frame_scrambler30;

    localparam logic [29:0] SEED = 30'h2AAAAAAA;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        init = 1'b0;
    logic [29:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [29:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] frame_cnt;
    logic        tmr_error;

    frame_scrambler30 dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .init      (init),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_cnt (frame_cnt),
        .tmr_error (tmr_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] exp;
        logic [29:0] plain;
        int          lb_n;
    } entry_t;

    entry_t      sb[$];
    bit          hist[$];
    logic [15:0] cnt_m;
    int          vectors = 0;
    int          miscmp = 0;
    bit          lb_phase = 0;
    int          lb_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic set_hist(input logic [29:0] s);
        hist.delete();
        for (int j = 0; j < 30; j++) hist.push_back(s[j]);
    endtask

    // reference: serial scrambler over the bit stream, taps at -30,-29,-15,-14
    task automatic model_accept(input logic [29:0] d, input logic en, input logic ini);
        entry_t e;
        logic [29:0] y;
        bit b;
        if (en) begin
            for (int i = 0; i < 30; i++) begin
                b = d[i] ^ hist[0] ^ hist[1] ^ hist[15] ^ hist[16];
                y[i] = b;
                void'(hist.pop_front());
                hist.push_back(b);
            end
            cnt_m = cnt_m + 16'd1;
        end else begin
            y = d;
        end
        if (ini) begin
            set_hist(SEED);
            cnt_m = '0;
        end
        e.exp   = y;
        e.plain = d;
        e.lb_n  = lb_phase ? lb_cnt : -1;
        if (lb_phase) lb_cnt++;
        sb.push_back(e);
    endtask

    // descrambler 1+x^14+x^15+x^29+x^30 over received bits: h holds previous frame
    function automatic logic [29:0] descr(input logic [29:0] y, input logic [29:0] h);
        logic [59:0] x;
        logic [29:0] d;
        x = {y, h};
        for (int i = 0; i < 30; i++)
            d[i] = y[i] ^ x[i] ^ x[i+1] ^ x[i+15] ^ x[i+16];
        return d;
    endfunction

    task automatic send(input logic [29:0] d, input logic en, input logic ini, input bit rnd_bp);
        bit done = 0;
        int guard = 0;
        while (!done) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = d;
            enable    = en;
            init      = ini;
            out_ready = rnd_bp ? ($urandom_range(0, 9) < 7) : 1'b1;
            #1;
            if (in_ready) begin
                model_accept(d, en, ini);
                done = 1;
            end else if (++guard > 100) begin
                check("accept_timeout", 32'd0, 32'd1);
                done = 1;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        init     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid  = 1'b0;
            init      = 1'b0;
            out_ready = 1'b1;
        end
        #1;
    endtask

    task automatic do_init();
        @(negedge clk);
        in_valid  = 1'b0;
        init      = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        set_hist(SEED);
        cnt_m = '0;
    endtask

    // monitor: peek while valid (checks hold under stall), pop on transfer
    logic [29:0] h1, h0;
    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset && out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", {2'b0, out_data}, 32'hFFFFFFFF);
                end else begin
                    e = sb[0];
                    check("out_data", {2'b0, out_data}, {2'b0, e.exp});
                    if (out_ready) begin
                        void'(sb.pop_front());
                        if (e.lb_n >= 0) begin
                            if (e.lb_n == 0) begin
                                h1 = SEED;
                                h0 = '0;
                            end
                            check("loopback_seeded", {2'b0, descr(out_data, h1)}, {2'b0, e.plain});
                            if (e.lb_n >= 1)
                                check("loopback_zero_seed", {2'b0, descr(out_data, h0)}, {2'b0, e.plain});
                            h1 = out_data;
                            h0 = out_data;
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [29:0] r;
        int guard;
        set_hist(SEED);
        cnt_m = '0;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", {2'b0, out_data}, 32'd0);
        check("rst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
        check("rst_tmr_error", {31'b0, tmr_error}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle(1);
        check("in_ready_after_rst", {31'b0, in_ready}, 32'd1);

        // first frame exposes the reset seed
        send(30'h0, 1'b1, 1'b0, 1'b0);
        idle(2);
        check("cnt_after_first", {16'b0, frame_cnt}, {16'b0, cnt_m});

        // bypass leaves state and counter alone
        send(30'h12345678, 1'b0, 1'b0, 1'b0);
        idle(2);
        check("cnt_after_bypass", {16'b0, frame_cnt}, {16'b0, cnt_m});
        send(30'($urandom()), 1'b1, 1'b0, 1'b0);
        send(30'($urandom()), 1'b0, 1'b0, 1'b0);
        send(30'($urandom()), 1'b1, 1'b0, 1'b0);

        // backpressure: 3 stalled cycles with a frame waiting
        send(30'($urandom()), 1'b1, 1'b0, 1'b0);
        r = 30'($urandom());
        repeat (3) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = r;
            enable    = 1'b1;
            out_ready = 1'b0;
            #1;
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        send(r, 1'b1, 1'b0, 1'b0);
        idle(2);
        check("cnt_after_bp", {16'b0, frame_cnt}, {16'b0, cnt_m});

        // init with simultaneous accept
        send(30'($urandom()), 1'b1, 1'b1, 1'b0);
        idle(1);
        check("cnt_after_init_acc", {16'b0, frame_cnt}, 32'd0);
        send(30'($urandom()), 1'b1, 1'b0, 1'b0);

        // counter wrap
        do_init();
        repeat (16'hFFFF) send(30'($urandom()), 1'b1, 1'b0, 1'b0);
        idle(2);
        check("cnt_full", {16'b0, frame_cnt}, 32'h0000FFFF);
        send(30'($urandom()), 1'b1, 1'b0, 1'b0);
        idle(2);
        check("cnt_wrap", {16'b0, frame_cnt}, 32'd0);

        // loopback with random backpressure and gaps
        do_init();
        lb_phase = 1;
        lb_cnt   = 0;
        for (int k = 0; k < 1000; k++) begin
            send(30'($urandom()), 1'b1, 1'b0, 1'b1);
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        idle(3);
        lb_phase = 0;
        check("cnt_after_loopback", {16'b0, frame_cnt}, {16'b0, cnt_m});

        // reset while a frame sits in the output register
        send(30'($urandom()), 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        sb.delete();
        set_hist(SEED);
        cnt_m = '0;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_out_data", {2'b0, out_data}, 32'd0);
        check("midrst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle(2);
        check("midrst_no_output", {31'b0, out_valid}, 32'd0);
        send(30'($urandom()), 1'b1, 1'b0, 1'b0);
        idle(2);

`ifdef SCRAMBLER_TMR_EN
        @(negedge clk);
        force dut.st_q[1] = '0;
        #1;
        release dut.st_q[1];
        check("tmr_err_pre", {31'b0, tmr_error}, 32'd0);
        @(posedge clk);
        #1;
        check("tmr_err_pulse", {31'b0, tmr_error}, 32'd1);
        @(posedge clk);
        #1;
        check("tmr_err_clear", {31'b0, tmr_error}, 32'd0);
        send(30'($urandom()), 1'b1, 1'b0, 1'b0);
        send(30'($urandom()), 1'b1, 1'b0, 1'b0);
        idle(2);
`endif

        // drain
        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            idle(1);
            guard++;
        end
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
        $finish;
    end

endmodule

// File: doc/frame_scrambler30.md
FRAME_SCRAMBLER30 -- requirements
Module: frame_scrambler30

Interface
- REQ-001 SHALL have parameter SEED, default 30'h2AAAAAAA, the scrambler state loaded at reset and on init.
- REQ-002 SHALL have parameter CNT_W, default 16, the width of the frame counter.
- REQ-003 SHALL have port clk, input, 1, the clock; every register updates on the rising edge.
- REQ-004 SHALL have port reset, input, 1, asynchronous, active-low.
- REQ-005 SHALL have port enable, input, 1: 1 = scramble, 0 = bypass.
- REQ-006 SHALL have port init, input, 1: synchronous reload of state to SEED.
- REQ-007 SHALL have port in_data, input, 30, the plain frame.
- REQ-008 SHALL have port in_valid, input, 1, and port in_ready, output, 1, as the input handshake.
- REQ-009 SHALL have port out_data, output, 30, the scrambled frame.
- REQ-010 SHALL have port out_valid, output, 1, and port out_ready, input, 1, as the output handshake.
- REQ-011 SHALL have port frame_cnt, output, CNT_W, the count of scrambled frames accepted.
- REQ-012 SHALL have port tmr_error, output, 1, a one-cycle pulse on a voter mismatch.

Function
- REQ-013 SHALL accept a frame when in_valid && in_ready, with in_ready = !out_valid || out_ready.
- REQ-014 SHALL present out_data one cycle after acceptance (latency 1) and hold it stable while out_valid && !out_ready.
- REQ-015 SHALL set out_valid on acceptance, keep it set until out_ready, and sustain one frame per cycle when out_ready = 1.
- REQ-016 SHALL number bits as X[0..29] = state[0..29] and X[30+i] = out_data[i]; in scramble mode, y[i] = in_data[i] ^ X[i] ^ X[i+1] ^ X[i+15] ^ X[i+16], evaluated for i = 0..29 in ascending order, so that bits above 29 are the already-computed y bits.
- REQ-017 SHALL load state <= y on each scrambled acceptance, making the output self-synchronising to the 30-bit descrambler polynomial 1+x^14+x^15+x^29+x^30.
- REQ-018 SHALL, when an accepted frame has enable = 0, output out_data = in_data and leave state and frame_cnt unchanged.
- REQ-019 SHALL increment frame_cnt by 1 per scrambled acceptance, wrapping modulo 2^CNT_W (all-ones -> 0).
- REQ-020 SHALL, on init = 1, set state <= SEED and frame_cnt <= 0; a frame accepted in the same cycle is scrambled with the old state, and init wins the state and counter update.
- REQ-021 SHALL ignore in_data and enable when no acceptance occurs; state is unchanged.

Reset
- REQ-022 SHALL apply, while reset = 0: state = SEED, out_data = 0, out_valid = 0, frame_cnt = 0, tmr_error = 0; in_ready = 1 one cycle after deassertion.
- REQ-023 SHALL drop a frame held in the output register when reset is asserted mid-transfer, with no partial output.

Configuration
- REQ-024 SHALL, with SCRAMBLER_TMR_EN defined, triplicate state, out_data, out_valid and frame_cnt, with every next-state computed from 2-of-3 majority-voted values; outputs are voted, and tmr_error pulses for one cycle when any copy disagrees.
- REQ-025 SHALL, without SCRAMBLER_TMR_EN, use single registers and tie tmr_error to 0; the port list is identical in both builds.

Structure
- REQ-026 SHALL place FRAME_W = 30, the default SEED and the tap list {0, 1, 15, 16} in shared package scrambler_pkg.
- REQ-027 SHALL isolate the combinational scramble equation in a sub-module scrambler30_core (inputs data, state; output y), and reuse the existing 30-bit majority voter for TMR.

Verification
- REQ-028 SHALL check reset: reset low -> out_valid = 0, out_data = 0, frame_cnt = 0, internal state = 30'h2AAAAAAA.
- REQ-029 SHALL check bypass: enable = 0, in_data = 30'h12345678 -> out_data = 30'h12345678 next cycle, and state and frame_cnt unchanged.
- REQ-030 SHALL check loopback: 1000 random frames into the descrambler seeded 30'h2AAAAAAA -> all frames match from frame 1; with the descrambler seeded 0 -> all frames match from frame 2 onward.
- REQ-031 SHALL check backpressure: out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, out_data held, no frame lost or duplicated.
- REQ-032 SHALL check counter wrap and init: frame_cnt = 16'hFFFF plus one frame -> 16'h0000; init together with an accept -> frame scrambled with the old state, then state = SEED and frame_cnt = 0.
- REQ-033 SHALL check TMR (SCRAMBLER_TMR_EN only): force one state copy to 0 -> out_data unchanged, tmr_error = 1 for one cycle, and the copy is repaired on the next accept.
